// File: rtl/tetris_pkg.sv
// Shared shape constants and generator state encoding.
// Used by the bag generator and the bitmap decoder.
package tetris_pkg;

  localparam int SHAPE_W    = 3;
  localparam int NUM_SHAPES = 7;

  localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd5;
  localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd6;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    FILL_CUR,
    FILL_NEXT,
    READY,
    DRAW
  } bag_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free running.
// A zero load value is replaced by the seed so it never locks up.
module lfsr16
  import tetris_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst)
      state <= SEED;
    else if (load)
      state <= (load_val == 16'd0) ? SEED : load_val;
    else
      state <= {1'b0, state[15:1]}
             ^ (state[0] ? LFSR_POLY : 16'd0);
  end

endmodule

// File: rtl/shape_bag_generator.sv
// 7-bag shape source: current and preview ids
// handed over on a req/valid handshake.
module shape_bag_generator
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [15:0]        seed_val,
  input  logic               req,
  output logic [SHAPE_W-1:0] shape_id,
  output logic [SHAPE_W-1:0] next_id,
  output logic               valid,
  output logic [2:0]         bag_remaining
);

  localparam logic [2:0] LAST = 3'(MAX_TRIES - 1);

  bag_state_t            state;
  logic [NUM_SHAPES-1:0] used;
  logic [2:0]            tries;
  logic [15:0]           lfsr;
  logic                  unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed_val),
    .state    (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:3];

  logic [2:0]            cand;
  logic [7:0]            used8;
  logic                  hit;
  logic                  done_draw;
  logic [2:0]            first_free;
  logic [2:0]            pick;
  logic [NUM_SHAPES-1:0] set_mask;
  logic [NUM_SHAPES-1:0] nxt_used;
  logic [2:0]            cnt;
  logic [2:0]            rem;

  // bit 7 stands in for the never-valid candidate 7
  assign cand      = lfsr[2:0];
  assign used8     = {1'b1, used};
  assign hit       = ~used8[cand];
  assign done_draw = hit || (tries == LAST);

  always_comb begin
    first_free = 3'd0;
    for (int i = NUM_SHAPES - 1; i >= 0; i--)
      if (!used[i]) first_free = 3'(i);
  end

  assign pick     = hit ? cand : first_free;
  assign set_mask = used | (7'd1 << pick);
  assign nxt_used = (&set_mask) ? '0 : set_mask;

  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < NUM_SHAPES; i++)
      cnt = cnt + 3'(nxt_used[i]);
  end

  assign rem = 3'd7 - cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL_CUR;
      used          <= '0;
      tries         <= 3'd0;
      shape_id      <= SHAPE_O;
      next_id       <= SHAPE_O;
      valid         <= 1'b0;
      bag_remaining <= 3'd7;
    end else if (seed_load) begin
      state         <= FILL_CUR;
      used          <= '0;
      tries         <= 3'd0;
      valid         <= 1'b0;
      bag_remaining <= 3'd7;
    end else begin
      unique case (state)
        READY: begin
          if (req) begin
            shape_id <= next_id;
            valid    <= 1'b0;
            state    <= DRAW;
          end
        end
        FILL_CUR, FILL_NEXT, DRAW: begin
          if (done_draw) begin
            if (state == FILL_CUR)
              shape_id <= pick;
            else
              next_id <= pick;
            used          <= nxt_used;
            bag_remaining <= rem;
            tries         <= 3'd0;
            valid         <= (state != FILL_CUR);
            state         <= (state == FILL_CUR)
                           ? FILL_NEXT : READY;
          end else begin
            tries <= tries + 3'd1;
          end
        end
      endcase
    end
  end

endmodule
